// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, captures the ROM word into a one-entry IR and offers it
// to decode with a valid/ready handshake; execute can redirect the PC at any time.
//
// state | meaning
// FETCH | IR empty; capture imem_data at pc on the next unstalled edge
// HOLD  | IR valid; wait for decode to accept it
module fetch_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter int PC_STEP = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_data,
  input  logic                  stall,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  ir_valid,
  input  logic                  ir_ready,
  output logic [DATA_WIDTH-1:0] ir_out,
  output logic [ADDR_WIDTH-1:0] ir_pc,
  output logic [ADDR_WIDTH-1:0] ir_pc_next,
  output logic [31:0]           fetch_count
);

  localparam logic [0:0] FETCH = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  logic [0:0]            state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] redirect_aligned;

  assign pc_inc           = pc + ADDR_WIDTH'(PC_STEP);
  assign redirect_aligned = redirect_pc & ~(ADDR_WIDTH'(3));
  assign imem_addr        = pc;
  // Valid is decoded from the registered state so reset clears it asynchronously.
  assign ir_valid         = (state == HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      ir_out      <= '0;
      ir_pc       <= '0;
      ir_pc_next  <= '0;
      fetch_count <= '0;
    end else if (redirect_valid) begin
      // Flush: stale IR contents stay put, decode qualifies them with ir_valid.
      state <= FETCH;
      pc    <= redirect_aligned;
    end else begin
      case (state)
        FETCH: begin
          if (!stall) begin
            ir_out     <= imem_data;
            ir_pc      <= pc;
            ir_pc_next <= pc_inc;
            pc         <= pc_inc;
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (ir_ready) begin
            fetch_count <= fetch_count + 32'd1;
            state       <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed table-driven bench for fetch_unit with a small combinational ROM model,
// plus a hand-written asynchronous reset-in-HOLD sequence.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] ir_out;
  logic [31:0] ir_pc;
  logic [31:0] ir_pc_next;
  logic [31:0] fetch_count;

  int n_cmp = 0;
  int n_err = 0;

  fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ir_valid       (ir_valid),
    .ir_ready       (ir_ready),
    .ir_out         (ir_out),
    .ir_pc          (ir_pc),
    .ir_pc_next     (ir_pc_next),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    case (imem_addr)
      32'h0000_0000: imem_data = 32'h0000_10b7;
      32'h0000_0004: imem_data = 32'h0002_0137;
      32'h0000_0008: imem_data = 32'h0030_8193;
      32'h0000_002C: imem_data = 32'h00a0_0293;
      default:       imem_data = 32'h0000_0033;
    endcase
  end

  typedef struct {
    logic        stall;
    logic        rdv;
    logic [31:0] rpc;
    logic        ready;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] ir;
    logic [31:0] irpc;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic s, logic rv, logic [31:0] rp, logic rdy, logic v,
                              logic [31:0] a, logic [31:0] i, logic [31:0] ip,
                              logic [31:0] c);
    vec_t t;
    t.stall = s; t.rdv = rv; t.rpc = rp; t.ready = rdy; t.valid = v;
    t.addr = a; t.ir = i; t.irpc = ip; t.cnt = c;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          stall rdv rpc            rdy valid addr          ir            irpc          cnt
    vecs.push_back(mk(0, 0, 32'h0,          1, 1, 32'h4,        32'h0000_10b7, 32'h0,        0)); // test 1
    vecs.push_back(mk(0, 0, 32'h0,          1, 0, 32'h4,        32'h0,         32'h0,        1));
    vecs.push_back(mk(0, 0, 32'h0,          1, 1, 32'h8,        32'h0002_0137, 32'h4,        1));
    vecs.push_back(mk(0, 0, 32'h0,          1, 0, 32'h8,        32'h0,         32'h0,        2));
    vecs.push_back(mk(0, 0, 32'h0,          0, 1, 32'hC,        32'h0030_8193, 32'h8,        2)); // test 2
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'hC,        32'h0030_8193, 32'h8,        2));
    vecs.push_back(mk(0, 1, 32'h2E,         1, 0, 32'h2C,       32'h0,         32'h0,        2)); // test 3
    vecs.push_back(mk(0, 0, 32'h0,          1, 1, 32'h30,       32'h00a0_0293, 32'h2C,       2));
    vecs.push_back(mk(0, 0, 32'h0,          1, 0, 32'h30,       32'h0,         32'h0,        3));
    for (int k = 0; k < 3; k++)                                                                  // test 4
      vecs.push_back(mk(1, 0, 32'h0,        1, 0, 32'h30,       32'h0,         32'h0,        3));
    vecs.push_back(mk(0, 0, 32'h0,          1, 1, 32'h34,       32'h0000_0033, 32'h30,       3));
    vecs.push_back(mk(1, 0, 32'h0,          1, 0, 32'h34,       32'h0,         32'h0,        4)); // stall ignored in HOLD
    vecs.push_back(mk(0, 1, 32'hFFFF_FFFC,  0, 0, 32'hFFFF_FFFC, 32'h0,        32'h0,        4)); // test 5
    vecs.push_back(mk(0, 0, 32'h0,          0, 1, 32'h0,        32'h0000_0033, 32'hFFFF_FFFC, 4));
    vecs.push_back(mk(0, 0, 32'h0,          1, 0, 32'h0,        32'h0,         32'h0,        5));
    vecs.push_back(mk(0, 0, 32'h0,          1, 1, 32'h4,        32'h0000_10b7, 32'h0,        5));
    vecs.push_back(mk(0, 1, 32'h7,          1, 0, 32'h4,        32'h0,         32'h0,        5)); // redirect beats ready
    vecs.push_back(mk(0, 0, 32'h0,          0, 1, 32'h8,        32'h0002_0137, 32'h4,        5));

    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; ir_ready = 1'b0;
    step();
    chk("reset_valid", {31'd0, ir_valid}, 32'd0);
    chk("reset_addr", imem_addr, 32'h0);
    chk("reset_ir_out", ir_out, 32'h0);
    chk("reset_ir_pc", ir_pc, 32'h0);
    chk("reset_ir_pc_next", ir_pc_next, 32'h0);
    chk("reset_count", fetch_count, 32'h0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      stall = vecs[i].stall; redirect_valid = vecs[i].rdv;
      redirect_pc = vecs[i].rpc; ir_ready = vecs[i].ready;
      step();
      chk($sformatf("v%0d_valid", i), {31'd0, ir_valid}, {31'd0, vecs[i].valid});
      chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].addr);
      chk($sformatf("v%0d_count", i), fetch_count, vecs[i].cnt);
      if (vecs[i].valid) begin
        chk($sformatf("v%0d_ir_out", i), ir_out, vecs[i].ir);
        chk($sformatf("v%0d_ir_pc", i), ir_pc, vecs[i].irpc);
        chk($sformatf("v%0d_ir_pc_next", i), ir_pc_next, vecs[i].irpc + 32'd4);
      end
    end

    // Test 6: async reset between edges while in HOLD.
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, ir_valid}, 32'd0);
    chk("async_rst_addr", imem_addr, 32'h0);
    chk("async_rst_count", fetch_count, 32'h0);
    #1 rst_n = 1'b1;
    ir_ready = 1'b0;
    step();
    chk("post_rst_valid", {31'd0, ir_valid}, 32'd1);
    chk("post_rst_ir_pc", ir_pc, 32'h0);
    chk("post_rst_ir_out", ir_out, 32'h0000_10b7);
    chk("post_rst_addr", imem_addr, 32'h4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
